fir_sample_feeder: RTL and testbench

Paced input stage that sits directly upstream of the 32-tap time-multiplexed FIR filter. It accepts 16-bit samples from a bursty producer over a valid/ready handshake and buffers them in a small FIFO. It releases exactly one sample per `PERIOD` clocks as a held data word plus a one-cycle `sample` strobe. This guarantees that the FIR's 32-cycle multiply-accumulate pass completes before the next shift.

---
 rtl/fir_sample_feeder.sv | 148 ++++++++++++++
 tb/tb_fir_sample_feeder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: FIFO-buffered, paced sample source for the 32-tap time-multiplexed FIR.
// Optional macro FIR_FEEDER_ZERO_STUFF_EN: an empty tick emits a zero-valued strobe.
module fir_sample_feeder #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 8,
   parameter int PERIOD = 34
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       din,
   input  logic                   din_valid,
   output logic                   din_ready,
   output logic [WIDTH-1:0]       xOut,
   output logic                   sample,
   output logic [$clog2(DEPTH):0] level,
   output logic                   underrun
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(PERIOD);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_nxt_s;
   logic [PTR_W-1:0] rd_ptr_nxt_s;
   logic [LVL_W-1:0] level_r;
   logic [LVL_W-1:0] level_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [WIDTH-1:0] xout_r;
   logic [WIDTH-1:0] xout_nxt_s;
   logic             sample_r;
   logic             sample_nxt_s;
   logic             underrun_r;
   logic             underrun_nxt_s;
   logic             full_s;
   logic             empty_s;
   logic             tick_s;
   logic             push_s;
   logic             pop_s;

   // Status flags and handshake; ready is held low while reset is asserted.
   always_comb begin
      full_s    = (level_r == LVL_FULL);
      empty_s   = (level_r == {LVL_W{1'b0}});
      tick_s    = (cnt_r == CNT_LAST);
      din_ready = reset & ~full_s;
      push_s    = din_valid & din_ready;
      pop_s     = tick_s & ~empty_s;
   end

   // Pacer counter: 0..PERIOD-1, wrapping on tick.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (tick_s) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end
   end

   // Pointer and occupancy update; a simultaneous push and pop leaves level unchanged.
   always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      level_nxt_s  = level_r;
      if (push_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_ONE;
         2'b01:   level_nxt_s = level_r - LVL_ONE;
         default: level_nxt_s = level_r;
      endcase
   end

   // Strobe, data and underrun generation for the following cycle.
   always_comb begin
      xout_nxt_s     = xout_r;
      sample_nxt_s   = 1'b0;
      underrun_nxt_s = 1'b0;
      if (pop_s) begin
         xout_nxt_s   = mem_r[rd_ptr_r];
         sample_nxt_s = 1'b1;
      end else if (tick_s) begin
         underrun_nxt_s = 1'b1;
`ifdef FIR_FEEDER_ZERO_STUFF_EN
         // Keep the FIR sample rate constant by feeding a zero.
         sample_nxt_s = 1'b1;
         xout_nxt_s   = {WIDTH{1'b0}};
`else
         sample_nxt_s = 1'b0;
         xout_nxt_s   = xout_r;
`endif
      end else begin
         xout_nxt_s = xout_r;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         level_r    <= {LVL_W{1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         xout_r     <= {WIDTH{1'b0}};
         sample_r   <= 1'b0;
         underrun_r <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_ptr_nxt_s;
         rd_ptr_r   <= rd_ptr_nxt_s;
         level_r    <= level_nxt_s;
         cnt_r      <= cnt_nxt_s;
         xout_r     <= xout_nxt_s;
         sample_r   <= sample_nxt_s;
         underrun_r <= underrun_nxt_s;
      end
   end

   // Sample storage; stale contents are unreachable once the pointers are cleared.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   assign xOut     = xout_r;
   assign sample   = sample_r;
   assign level    = level_r;
   assign underrun = underrun_r;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder: vector table, directed corner sequences and
// randomized traffic compared each cycle against a queue-based reference model.
module tb_fir_sample_feeder;

   localparam int WIDTH  = 16;
   localparam int DEPTH  = 8;
   localparam int PERIOD = 34;
   localparam int LVL_W  = $clog2(DEPTH) + 1;
`ifdef FIR_FEEDER_ZERO_STUFF_EN
   localparam bit ZS = 1'b1;
`else
   localparam bit ZS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             din_valid = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic             din_ready;
   logic [WIDTH-1:0] xOut;
   logic             sample;
   logic [LVL_W-1:0] level;
   logic             underrun;

   always #5 clk = ~clk;

   fir_sample_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PERIOD(PERIOD)) dut (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .xOut(xOut), .sample(sample), .level(level), .underrun(underrun));

   int n_vec = 0;
   int n_err = 0;

   // Reference model: sample queue plus cycle number since reset release.
   logic [WIDTH-1:0] q[$];
   int               cyc = 0;
   logic [WIDTH-1:0] m_x = '0;
   bit               m_sample = 1'b0;
   bit               m_under = 1'b0;
   bit               last_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: actual 0x%0h required 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic do_cycle(input bit rst_n, input bit v, input logic [WIDTH-1:0] d);
      bit exp_ready;
      bit accept;
      @(negedge clk);
      reset = rst_n;
      din_valid = v;
      din = d;
      #1;
      exp_ready = rst_n && (q.size() < DEPTH);
      last_ready = din_ready;
      check("din_ready", din_ready, exp_ready);
      accept = exp_ready && v;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         q.delete();
         cyc = 0;
         m_x = '0;
         m_sample = 1'b0;
         m_under = 1'b0;
      end else begin
         m_sample = 1'b0;
         m_under = 1'b0;
         if (cyc % PERIOD == PERIOD - 1) begin
            if (q.size() > 0) begin
               m_x = q.pop_front();
               m_sample = 1'b1;
            end else begin
               m_under = 1'b1;
               if (ZS) begin
                  m_sample = 1'b1;
                  m_x = '0;
               end
            end
         end
         if (accept) q.push_back(d);
         cyc++;
      end
      check("sample", sample, m_sample);
      check("xOut", xOut, m_x);
      check("level", level, 32'(q.size()));
      check("underrun", underrun, m_under);
   endtask

   task automatic run_until(input int n);
      while (cyc < n) do_cycle(1'b1, 1'b0, '0);
   endtask

   typedef struct {
      bit         rst_n;
      bit         v;
      logic [15:0] d;
      bit         e_ready;
      bit         e_sample;
      logic [15:0] e_x;
      int         e_level;
      bit         e_under;
   } vec_t;

   vec_t tbl[8];
   int   acc;
   int   pct_tbl[6];

   initial begin
      tbl[0] = '{1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 0, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 16'h0000, 1, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0000, 2, 1'b0};
      tbl[5] = '{1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, 16'h0000, 3, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3, 1'b0};

      // Reset with valid held high, then the burst pushes.
      for (int i = 0; i < 8; i++) begin
         do_cycle(tbl[i].rst_n, tbl[i].v, tbl[i].d);
         check("tbl_ready", last_ready, tbl[i].e_ready);
         check("tbl_sample", sample, tbl[i].e_sample);
         check("tbl_xOut", xOut, tbl[i].e_x);
         check("tbl_level", level, tbl[i].e_level);
         check("tbl_underrun", underrun, tbl[i].e_under);
      end

      // Burst strobes at cycles 34, 68, 102.
      run_until(34);
      check("burst1_sample", sample, 1);
      check("burst1_x", xOut, 16'h0001);
      check("burst1_level", level, 2);
      run_until(68);
      check("burst2_x", xOut, 16'h0002);
      check("burst2_level", level, 1);
      run_until(102);
      check("burst3_x", xOut, 16'h7FFF);
      check("burst3_level", level, 0);
      run_until(103);
      check("burst_hold_sample", sample, 0);
      check("burst_hold_x", xOut, 16'h7FFF);

      // Full / backpressure with valid held high from cycle 0.
      do_cycle(1'b0, 1'b0, '0);
      acc = 0;
      for (int i = 0; i <= 34; i++) begin
         do_cycle(1'b1, 1'b1, 16'(16'h0100 + i));
         if (i <= 33 && last_ready) acc++;
         if (i == 7) check("full_level8", level, 8);
         if (i == 8) check("full_ready_c8", last_ready, 0);
         if (i == 33) begin
            check("full_ready_c33", last_ready, 0);
            check("full_pushes_0_33", acc, 8);
            check("full_pop_x", xOut, 16'h0100);
            check("full_level_c33", level, 7);
         end
         if (i == 34) begin
            check("full_ready_c34", last_ready, 1);
            check("full_level_c34", level, 8);
         end
      end

      // Underrun with no pushes.
      do_cycle(1'b0, 1'b0, '0);
      run_until(34);
      check("under1", underrun, 1);
      check("under1_sample", sample, ZS);
      check("under1_x", xOut, 16'h0000);
      run_until(35);
      check("under1_end", underrun, 0);
      run_until(68);
      check("under2", underrun, 1);
      check("under2_sample", sample, ZS);

      // Push on an empty tick edge.
      do_cycle(1'b0, 1'b0, '0);
      run_until(33);
      do_cycle(1'b1, 1'b1, 16'h8000);
      check("coll_under", underrun, 1);
      check("coll_level", level, 1);
      check("coll_sample", sample, ZS);
      run_until(68);
      check("coll_sample2", sample, 1);
      check("coll_x", xOut, 16'h8000);
      check("coll_under2", underrun, 0);

      // Reset in mid-period with 5 queued entries.
      do_cycle(1'b0, 1'b0, '0);
      for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b1, 16'(16'h0A00 + i));
      run_until(20);
      do_cycle(1'b0, 1'b1, 16'h1234);
      check("midrst_level", level, 0);
      run_until(34);
      check("midrst_sample", sample, ZS);
      check("midrst_under", underrun, 1);
      check("midrst_level2", level, 0);

      // Randomized traffic at several push densities with rare resets.
      pct_tbl = '{60, 3, 2, 10, 1, 50};
      do_cycle(1'b0, 1'b0, '0);
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < 500; i++) begin
            do_cycle(($urandom_range(599) != 0), ($urandom_range(99) < pct_tbl[p]),
                     16'($urandom));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
